// File: rtl/regfile4_onehot.sv
// Four-entry register file with one-hot write select, two registered read ports
// and a sticky malformed-select flag. Define REGFILE4_WR_BYPASS_EN to forward same-edge writes to reads.
module regfile4_onehot #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [3:0]       wr_sel,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [1:0]       rd_addr_a,
  input  logic [1:0]       rd_addr_b,
  output logic [WIDTH-1:0] rd_data_a,
  output logic [WIDTH-1:0] rd_data_b,
  output logic             rd_valid,
  output logic             sel_err
);

  logic [WIDTH-1:0] regs [4];
  logic             sel_onehot;
  logic             wr_ok;
  logic             wr_bad;
  logic [WIDTH-1:0] rd_val_a;
  logic [WIDTH-1:0] rd_val_b;

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
  assign sel_onehot = (wr_sel != 4'b0000) && ((wr_sel & (wr_sel - 4'd1)) == 4'b0000);
  assign wr_ok      = wr_en && sel_onehot;
  assign wr_bad     = wr_en && !sel_onehot;

`ifdef REGFILE4_WR_BYPASS_EN
  assign rd_val_a = (wr_ok && wr_sel[rd_addr_a]) ? wr_data : regs[rd_addr_a];
  assign rd_val_b = (wr_ok && wr_sel[rd_addr_b]) ? wr_data : regs[rd_addr_b];
`else
  assign rd_val_a = regs[rd_addr_a];
  assign rd_val_b = regs[rd_addr_b];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        regs[i] <= '0;
      end
      rd_data_a <= '0;
      rd_data_b <= '0;
      rd_valid  <= 1'b0;
      sel_err   <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (wr_ok && wr_sel[i]) begin
          regs[i] <= wr_data;
        end
      end
      if (rd_en) begin
        rd_data_a <= rd_val_a;
        rd_data_b <= rd_val_b;
      end
      rd_valid <= rd_en;
      if (wr_bad) begin
        sel_err <= 1'b1;
      end
    end
  end

endmodule

// File: doc/regfile4_onehot.md
Name: regfile4_onehot

Overview:
- Four-entry register file, the stage directly downstream of the 2-to-4 register-number decoder.
- Its write port takes the decoder's one-hot select as-is and latches write data into the selected register.
- Two independent read ports return registered data one cycle after a read request.
- A sticky flag reports any malformed (non-one-hot) write select.

Parameters:
- WIDTH, 8, data width of each register and of all data ports.

Ports:
- clk  input  1  single system clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- wr_en  input  1  write request qualifier.
- wr_sel  input  4  one-hot register select from the 2-to-4 decoder; bit i selects register i.
- wr_data  input  WIDTH  data to write.
- rd_en  input  1  read request for both read ports.
- rd_addr_a  input  2  read address, port A.
- rd_addr_b  input  2  read address, port B.
- rd_data_a  output  WIDTH  registered read data, port A.
- rd_data_b  output  WIDTH  registered read data, port B.
- rd_valid  output  1  one-cycle pulse: rd_data_a and rd_data_b are updated this cycle.
- sel_err  output  1  sticky error: a write was attempted with a non-one-hot wr_sel.

Behaviour:
- Reset, sampled at a rising clk edge with reset=1:
  - all four registers <= 0.
  - rd_data_a, rd_data_b, rd_valid, sel_err <= 0.
  - Reset has priority over every other input in the same cycle.
  - Any in-flight read is discarded: rd_valid is 0 in the cycle after reset.
- Write, at a rising edge with reset=0, wr_en=1 and wr_sel containing exactly one set bit (0001, 0010, 0100 or 1000):
  - reg[i] <= wr_data, where i is the set bit.
  - No other register changes.
- Malformed write, wr_en=1 with wr_sel = 0000 or two or more bits set:
  - no register is written.
  - sel_err <= 1 and stays 1 until reset; there is no other clear.
- wr_en=0: wr_sel is ignored entirely, including all-zero or multi-hot patterns; no write occurs and sel_err is unaffected.
- Read, when rd_en=1 at edge N:
  - rd_data_a <= reg[rd_addr_a] and rd_data_b <= reg[rd_addr_b], visible after edge N.
  - rd_valid = 1 for exactly the cycle after edge N.
  - Latency is 1 cycle; one new read is accepted every cycle, so back-to-back reads give a continuous rd_valid.
- rd_en=0 at edge N: rd_valid <= 0 and rd_data_a/rd_data_b hold their previous values.
- Both ports may read the same address; both return identical data.
- Simultaneous read and write of the same register at edge N, default build:
  - read-before-write: the read returns the value held before edge N.
  - The write still takes effect, so a read at edge N+1 returns the new value.
- Storage is plain flip-flops, no latches; the register file has no combinational outputs.
- Register contents are retained indefinitely while wr_en=0.

Optional Feature:
- Macro: REGFILE4_WR_BYPASS_EN.
- Defined: a read port whose address matches the register being written by a valid (one-hot) write at the same edge returns wr_data instead of the old value. Each port is checked independently.
  - Malformed writes are never forwarded.
  - Reset still wins over forwarding.
- Undefined: strict read-before-write as specified above. No forwarding logic is synthesised.

Test Plan:
- Reset for 2 cycles, then rd_en=1 with addr A=0, B=3 -> rd_data_a=0x00, rd_data_b=0x00, rd_valid=1 one cycle later, sel_err=0.
- Write 0xA5 with wr_sel=0100, then next cycle rd_en=1 with A=2, B=1 -> one cycle after rd_en: rd_data_a=0xA5, rd_data_b=0x00; rd_valid is high for exactly one cycle.
- Malformed writes:
  - Preload reg1=0x11, then wr_en=1, wr_sel=0110, wr_data=0xFF -> sel_err=1 after that edge; reading all registers gives reg1=0x11 and reg2 unchanged.
  - wr_en=1, wr_sel=0000 also sets sel_err.
  - sel_err stays 1 through 10 further clean writes and clears only on reset.
- Same-edge read/write collision: reg1=0x11, then at one edge write 0x3C with wr_sel=0010 while rd_en=1, A=1, B=1:
  - default build -> both ports return 0x11, and a read on the next edge returns 0x3C.
  - REGFILE4_WR_BYPASS_EN build -> both ports return 0x3C immediately.
- Reset mid-operation: reset=1 in the same cycle as wr_en=1, wr_sel=1000, wr_data=0x77 and rd_en=1 -> reg3 stays 0, rd_valid=0 on the next cycle, and all outputs are 0.
- Back-to-back reads with wr_en=0 and wr_sel=0000 for 4 cycles, addresses 0..3 on port A -> rd_valid is high for 4 consecutive cycles, the data matches each address in order, and sel_err stays 0.
